pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline registers (fetch2dec, dec2exec, exec2mem, mem2wb) and the PC.

---
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline registers and PC.
// Covers load-use, taken branch, multi-cycle mult/div and data-memory waits, and keeps perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MD_CYCLES      = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr,
  input  logic                      id_uses_rs,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic                      ex_wb_reg,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_branch_taken,
  input  logic                      ex_md_op,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  output logic                      pc_stall,
  output logic                      f2d_stall,
  output logic                      f2d_flush,
  output logic                      d2e_stall,
  output logic                      d2e_flush,
  output logic                      e2m_stall,
  output logic                      e2m_flush,
  output logic                      m2w_flush,
  output logic                      md_busy,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      branch_flushes
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0]        MD_LOAD = CW'(MD_CYCLES - 1);
  localparam logic [CW-1:0]        CNT_DEC = CW'(1);
  localparam logic [CNT_WIDTH-1:0] PERF_INC = CNT_WIDTH'(1);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          mem_wait;
  logic          md_hold;
  logic          lu;
  logic          br;

  assign mem_wait = mem_req & ~mem_ready;
  assign md_hold  = ((state == RUN) & ex_md_op) | ((state == MD_WAIT) & (cnt != '0));
  assign lu       = ex_mem_read & ex_wb_reg & (ex_rd_addr != '0) &
                    ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
                     (id_uses_rt & (id_rt_addr == ex_rd_addr)));
  assign br       = ex_branch_taken & ~mem_wait & ~md_hold;
  assign md_busy  = (state == MD_WAIT);

  // Priority chain: each branch leaves stall and flush of a register mutually exclusive.
  always_comb begin
    pc_stall  = 1'b0;
    f2d_stall = 1'b0;
    f2d_flush = 1'b0;
    d2e_stall = 1'b0;
    d2e_flush = 1'b0;
    e2m_stall = 1'b0;
    e2m_flush = 1'b0;
    m2w_flush = 1'b0;
    if (mem_wait) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_stall = 1'b1;
      m2w_flush = 1'b1;
    end else if (md_hold) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2e_stall = 1'b1;
      e2m_flush = 1'b1;
    end else if (br) begin
      f2d_flush = 1'b1;
      d2e_flush = 1'b1;
    end else if (lu) begin
      pc_stall  = 1'b1;
      f2d_stall = 1'b1;
      d2e_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      cnt            <= '0;
      stall_cycles   <= '0;
      branch_flushes <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_md_op) begin
            state <= MD_WAIT;
            cnt   <= MD_LOAD;
          end
        end
        default: begin
          // Countdown continues through memory waits; release waits for the memory.
          if (cnt != '0) begin
            cnt <= cnt - CNT_DEC;
          end else if (!mem_wait) begin
            state <= RUN;
          end
        end
      endcase
      if (pc_stall) stall_cycles   <= stall_cycles + PERF_INC;
      if (br)       branch_flushes <= branch_flushes + PERF_INC;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected flags/counters,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int RAW = 5;
  localparam int CNT = 4;

  // flag order: pc_stall f2d_stall f2d_flush d2e_stall d2e_flush e2m_stall e2m_flush m2w_flush md_busy
  localparam logic [8:0] F_NONE = 9'b000000000;
  localparam logic [8:0] F_LU   = 9'b110010000;
  localparam logic [8:0] F_BR   = 9'b001010000;
  localparam logic [8:0] F_MEMW = 9'b110101010;
  localparam logic [8:0] F_MDH  = 9'b110100100;
  localparam logic [8:0] F_BUSY = 9'b000000001;

  logic clk = 1'b0;
  logic rst;
  logic [RAW-1:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_wb_reg, ex_branch_taken, ex_md_op, mem_req, mem_ready;
  logic pc_stall, f2d_stall, f2d_flush, d2e_stall, d2e_flush, e2m_stall, e2m_flush, m2w_flush, md_busy;
  logic [CNT-1:0] stall_cycles, branch_flushes;

  typedef struct {
    string          name;
    logic [8:0]     flags;
    logic [CNT-1:0] sc;
    logic [CNT-1:0] bf;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  logic [CNT-1:0] sc_tally = '0;
  logic [CNT-1:0] bf_tally = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .MD_CYCLES(4), .CNT_WIDTH(CNT)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_wb_reg(ex_wb_reg), .ex_rd_addr(ex_rd_addr),
    .ex_branch_taken(ex_branch_taken), .ex_md_op(ex_md_op),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .f2d_stall(f2d_stall), .f2d_flush(f2d_flush),
    .d2e_stall(d2e_stall), .d2e_flush(d2e_flush),
    .e2m_stall(e2m_stall), .e2m_flush(e2m_flush), .m2w_flush(m2w_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles), .branch_flushes(branch_flushes)
  );

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e   = sb.pop_front();
      got = {pc_stall, f2d_stall, f2d_flush, d2e_stall, d2e_flush,
             e2m_stall, e2m_flush, m2w_flush, md_busy};
      total++;
      if (got !== e.flags) begin
        bad++;
        $display("FAIL %s flags got=%b want=%b", e.name, got, e.flags);
      end
      total++;
      if (stall_cycles !== e.sc) begin
        bad++;
        $display("FAIL %s stall_cycles got=%0d want=%0d", e.name, stall_cycles, e.sc);
      end
      total++;
      if (branch_flushes !== e.bf) begin
        bad++;
        $display("FAIL %s branch_flushes got=%0d want=%0d", e.name, branch_flushes, e.bf);
      end
    end
  end

  task automatic idle_in();
    id_rs_addr = '0; id_rt_addr = '0; ex_rd_addr = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_wb_reg = 1'b0;
    ex_branch_taken = 1'b0; ex_md_op = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [RAW-1:0] rd, input logic [RAW-1:0] rs, input logic urs,
                        input logic [RAW-1:0] rt, input logic urt);
    ex_mem_read = 1'b1; ex_wb_reg = 1'b1; ex_rd_addr = rd;
    id_rs_addr = rs; id_uses_rs = urs; id_rt_addr = rt; id_uses_rt = urt;
  endtask

  // Push expectation for this cycle (counters show totals before it), then advance.
  task automatic step(input string name, input logic [8:0] flags);
    exp_t e;
    e.name = name; e.flags = flags; e.sc = sc_tally; e.bf = bf_tally;
    sb.push_back(e);
    if (flags[8]) sc_tally = sc_tally + 4'd1;
    if (flags[6]) bf_tally = bf_tally + 4'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sc_tally = '0;
    bf_tally = '0;
  endtask

  initial begin
    idle_in();
    do_reset();
    step("reset_idle", F_NONE);

    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); step("lu_rs", F_LU);
    idle_in(); step("after_lu", F_NONE);
    set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); step("lu_rd0", F_NONE);
    set_lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1); step("lu_rt", F_LU);
    set_lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0); step("lu_unused", F_NONE);
    set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); ex_wb_reg = 1'b0; step("lu_nowb", F_NONE);
    idle_in(); ex_branch_taken = 1'b1; step("branch", F_BR);
    set_lu(5'd3, 5'd3, 1'b1, 5'd0, 1'b0); step("branch_over_lu", F_BR);

    idle_in(); ex_md_op = 1'b1;
    step("md_c0", F_MDH);
    step("md_c1", F_MDH | F_BUSY);
    step("md_c2", F_MDH | F_BUSY);
    step("md_c3", F_MDH | F_BUSY);
    step("md_release", F_NONE | F_BUSY);
    ex_md_op = 1'b0; step("md_done", F_NONE);

    idle_in(); mem_req = 1'b1; ex_branch_taken = 1'b1;
    step("memw_c0", F_MEMW);
    step("memw_c1", F_MEMW);
    step("memw_c2", F_MEMW);
    mem_ready = 1'b1; step("memw_branch_after", F_BR);
    idle_in(); step("memw_done", F_NONE);

    ex_md_op = 1'b1; step("ov_c0", F_MDH);
    mem_req = 1'b1; step("ov_memw_cnt3", F_MEMW | F_BUSY);
    step("ov_memw_cnt2", F_MEMW | F_BUSY);
    mem_req = 1'b0; step("ov_cnt1", F_MDH | F_BUSY);
    mem_req = 1'b1; step("ov_cnt0_wait", F_MEMW | F_BUSY);
    step("ov_cnt0_wait2", F_MEMW | F_BUSY);
    mem_ready = 1'b1; step("ov_release", F_NONE | F_BUSY);
    idle_in(); step("ov_run", F_NONE);

    ex_md_op = 1'b1; step("rst_md_c0", F_MDH);
    step("rst_md_c1", F_MDH | F_BUSY);
    idle_in(); do_reset();
    step("rst_mid_md", F_NONE);

    set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    for (int unsigned i = 0; i < 17; i++) step("wrap_lu", F_LU);
    idle_in(); ex_branch_taken = 1'b1;
    for (int unsigned i = 0; i < 17; i++) step("wrap_br", F_BR);
    idle_in(); step("wrap_check", F_NONE);

    for (int unsigned i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
